alu_hazard_ctrl: RTL and testbench

Hazard and forwarding controller for the 5-stage pipelined CPU. It shadows the destination registers of instructions in EX, MEM and WB in an internal scoreboard and decides, per cycle, whether the ID instruction may issue to the ALU. It raises a one-cycle load-use stall or a branch/jump flush, and registers the operand-forwarding selects used by the ALU operand muxes when that instruction executes. It sits beside the ID/EX pipeline register and receives branch resolution from the EX stage.

---
 rtl/alu_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: tracks EX/MEM/WB
// destinations, detects load-use stalls, raises redirect flushes and registers ALU operand selects.
module alu_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_func,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             ex_redirect,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic       ld;
        logic [4:0] dst;
    } slot_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Youngest writer (EX slot, next cycle's MEM) wins over the older MEM slot.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic used,
                                           input slot_t ex_s, input slot_t mem_s);
        logic [1:0] sel;
        sel = 2'b00;
        if (used && ex_s.valid && ex_s.wr && (ex_s.dst == src)) begin
            sel = 2'b01;
        end else if (used && mem_s.valid && mem_s.wr && (mem_s.dst == src)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    slot_t      ex_q, mem_q, wb_q;
    slot_t      ex_d;
    state_t     state_q, state_d;
    logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, stall_cnt_d, flush_cnt_d;

    logic       dec_wr_s, dec_ld_s, use_rs_s, use_rt_s;
    logic [4:0] dec_dst_s;
    logic       hazard_s, issue_s;

    // Decode destination and source usage of the ID instruction.
    always_comb begin
        dec_wr_s  = 1'b0;
        dec_ld_s  = 1'b0;
        dec_dst_s = 5'd0;
        use_rs_s  = 1'b1;
        use_rt_s  = 1'b0;
        case (id_opcode)
            OP_RTYPE: begin
                use_rt_s = 1'b1;
                if (id_func != FN_JR) begin
                    dec_wr_s  = 1'b1;
                    dec_dst_s = id_rd;
                end else begin
                    dec_wr_s = 1'b0;
                end
                if ((id_func == FN_SLL) || (id_func == FN_SRL) || (id_func == FN_SRA)) begin
                    use_rs_s = 1'b0;
                end else begin
                    use_rs_s = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
                dec_wr_s  = 1'b1;
                dec_dst_s = id_rt;
            end
            OP_LW: begin
                dec_wr_s  = 1'b1;
                dec_ld_s  = 1'b1;
                dec_dst_s = id_rt;
            end
            OP_JAL: begin
                dec_wr_s  = 1'b1;
                dec_dst_s = 5'd31;
                use_rs_s  = 1'b0;
            end
            OP_J: begin
                use_rs_s = 1'b0;
            end
            OP_BEQ, OP_BNE, OP_SW: begin
                use_rt_s = 1'b1;
            end
            default: begin
                dec_wr_s = 1'b0;
            end
        endcase
        if (dec_dst_s == 5'd0) begin
            dec_wr_s = 1'b0;
        end else begin
            dec_wr_s = dec_wr_s;
        end
    end

    // Load-use detection against the EX slot; redirect outranks the stall.
    always_comb begin
        hazard_s = id_valid && ex_q.valid && ex_q.ld && ex_q.wr &&
                   ((use_rs_s && (ex_q.dst == id_rs)) || (use_rt_s && (ex_q.dst == id_rt)));
        flush    = ex_redirect;
        stall    = hazard_s && !ex_redirect;
        issue_s  = id_valid && !stall && !flush;
    end

    // Next scoreboard EX entry, forwarding selects and saturating counters.
    always_comb begin
        ex_d        = '0;
        fwd_a_d     = 2'b00;
        fwd_b_d     = 2'b00;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (issue_s) begin
            ex_d.valid = 1'b1;
            ex_d.wr    = dec_wr_s;
            ex_d.ld    = dec_ld_s;
            ex_d.dst   = dec_dst_s;
            fwd_a_d    = fwd_sel(id_rs, use_rs_s, ex_q, mem_q);
            fwd_b_d    = fwd_sel(id_rt, use_rt_s, ex_q, mem_q);
        end else begin
            ex_d = '0;
        end
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // FSM next state; informational only, outputs do not depend on it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (ex_redirect) begin
                    state_d = FLUSH;
                end else if (hazard_s) begin
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                end
            end
            STALL, FLUSH: begin
                if (ex_redirect) begin
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State registers: scoreboard shift, selects, counters and FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            state_q     <= RUN;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            state_q     <= state_d;
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_alu_hazard_ctrl.sv
// Directed self-checking bench for alu_hazard_ctrl; a second 3-bit-counter
// instance shares the stimulus so counter saturation is reachable quickly.
module tb_alu_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [5:0]  id_opcode, id_func;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        ex_redirect;
    logic        stall, flush, s_stall, s_flush;
    logic [1:0]  fwd_a, fwd_b, s_fwd_a, s_fwd_b;
    logic [15:0] stall_cnt, flush_cnt;
    logic [2:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_func(id_func), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_redirect(ex_redirect), .stall(stall), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    alu_hazard_ctrl #(.CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_func(id_func), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_redirect(ex_redirect), .stall(s_stall), .flush(s_flush),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic redir);
        id_valid = v; id_opcode = op; id_func = fn;
        id_rs = rs; id_rt = rt; id_rd = rd; ex_redirect = redir;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_ex_forward();
        do_reset();
        drive(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, 1'b0); // add $3,$1,$2
        step();
        drive(1'b1, 6'b000000, 6'b100010, 5'd3, 5'd3, 5'd4, 1'b0); // sub $4,$3,$3
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ex_fwd_stall got=%b exp=0", stall); end
        step();
        idle();
        n_checks++; if (fwd_a !== 2'b01) begin n_fail++; $display("FAIL ex_fwd_a got=%b exp=01", fwd_a); end
        n_checks++; if (fwd_b !== 2'b01) begin n_fail++; $display("FAIL ex_fwd_b got=%b exp=01", fwd_b); end
        step();
        n_checks++; if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL bubble_fwd_a got=%b exp=00", fwd_a); end
    endtask

    task automatic test_mem_forward();
        do_reset();
        drive(1'b1, 6'b001000, 6'd0, 5'd0, 5'd5, 5'd0, 1'b0); // addi $5,$0,7
        step();
        drive(1'b1, 6'b001000, 6'd0, 5'd5, 5'd5, 5'd0, 1'b0); // addi $5,$5,1
        step();
        n_checks++; if (fwd_a !== 2'b01) begin n_fail++; $display("FAIL addi_chain_fwd_a got=%b exp=01", fwd_a); end
        drive(1'b1, 6'b000000, 6'b100101, 5'd5, 5'd0, 5'd6, 1'b0); // or $6,$5,$0
        step();
        idle();
        n_checks++; if (fwd_a !== 2'b01) begin n_fail++; $display("FAIL youngest_fwd_a got=%b exp=01", fwd_a); end
        n_checks++; if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL youngest_fwd_b got=%b exp=00", fwd_b); end
        do_reset();
        drive(1'b1, 6'b001000, 6'd0, 5'd0, 5'd5, 5'd0, 1'b0); // addi $5,$0,7
        step();
        drive(1'b1, 6'b000000, 6'b000000, 5'd0, 5'd0, 5'd0, 1'b0); // nop
        step();
        drive(1'b1, 6'b000000, 6'b100101, 5'd5, 5'd0, 5'd6, 1'b0); // or $6,$5,$0
        step();
        idle();
        n_checks++; if (fwd_a !== 2'b10) begin n_fail++; $display("FAIL mem_fwd_a got=%b exp=10", fwd_a); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 6'b100011, 6'd0, 5'd1, 5'd8, 5'd0, 1'b0); // lw $8,0($1)
        step();
        drive(1'b1, 6'b000000, 6'b100000, 5'd8, 5'd2, 5'd9, 1'b0); // add $9,$8,$2
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%b exp=1", stall); end
        step();
        n_checks++; if (dut.ex_q.valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got=%b exp=0", dut.ex_q.valid); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once got=%b exp=0", stall); end
        step();
        idle();
        n_checks++; if (fwd_a !== 2'b10) begin n_fail++; $display("FAIL lu_fwd_a got=%b exp=10", fwd_a); end
        n_checks++; if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL lu_fwd_b got=%b exp=00", fwd_b); end
        n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    endtask

    task automatic test_redirect_priority();
        do_reset();
        drive(1'b1, 6'b100011, 6'd0, 5'd1, 5'd8, 5'd0, 1'b0); // lw $8,0($1)
        step();
        drive(1'b1, 6'b000000, 6'b100000, 5'd8, 5'd2, 5'd9, 1'b1); // add with redirect
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL redir_flush got=%b exp=1", flush); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL redir_stall got=%b exp=0", stall); end
        step();
        idle();
        n_checks++; if (dut.ex_q.valid !== 1'b0) begin n_fail++; $display("FAIL redir_squash got=%b exp=0", dut.ex_q.valid); end
        n_checks++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL redir_flush_cnt got=%0d exp=1", flush_cnt); end
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL redir_stall_cnt got=%0d exp=0", stall_cnt); end
        n_checks++; if (dut.state_q !== 2'd2) begin n_fail++; $display("FAIL redir_state got=%0d exp=2", dut.state_q); end
        step();
        n_checks++; if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL redir_state_run got=%0d exp=0", dut.state_q); end
    endtask

    task automatic test_zero_and_nonwriters();
        do_reset();
        drive(1'b1, 6'b001000, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0); // addi $0,$0,5
        step();
        drive(1'b1, 6'b000000, 6'b100000, 5'd0, 5'd0, 5'd1, 1'b0); // add $1,$0,$0
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall got=%b exp=0", stall); end
        step();
        n_checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL zero_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
        drive(1'b1, 6'b101011, 6'd0, 5'd2, 5'd7, 5'd0, 1'b0); // sw $7,0($2)
        step();
        drive(1'b1, 6'b000000, 6'b100000, 5'd7, 5'd7, 5'd10, 1'b0); // add $10,$7,$7
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sw_stall got=%b exp=0", stall); end
        step();
        idle();
        n_checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL sw_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 6'b100011, 6'd0, 5'd1, 5'd8, 5'd0, 1'b0); // lw $8,0($1)
        step();
        drive(1'b1, 6'b100011, 6'd0, 5'd8, 5'd9, 5'd0, 1'b0); // lw $9,0($8)
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall1 got=%b exp=1", stall); end
        step();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_release1 got=%b exp=0", stall); end
        step();
        n_checks++; if (fwd_a !== 2'b10) begin n_fail++; $display("FAIL b2b_fwd1 got=%b exp=10", fwd_a); end
        drive(1'b1, 6'b000000, 6'b100000, 5'd9, 5'd9, 5'd10, 1'b0); // add $10,$9,$9
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall2 got=%b exp=1", stall); end
        step();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_release2 got=%b exp=0", stall); end
        step();
        idle();
        n_checks++; if ({fwd_a, fwd_b} !== 4'b1010) begin n_fail++; $display("FAIL b2b_fwd2 got=%b exp=1010", {fwd_a, fwd_b}); end
        n_checks++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL b2b_cnt got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL rst_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
        // Fill slots and counters, then reset mid-cycle during a pending stall.
        drive(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, 1'b1); // add with redirect (squashed)
        step();
        drive(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, 1'b0); // add $3,$1,$2
        step();
        drive(1'b1, 6'b000000, 6'b100010, 5'd3, 5'd3, 5'd4, 1'b0); // sub $4,$3,$3
        step();
        drive(1'b1, 6'b100011, 6'd0, 5'd1, 5'd8, 5'd0, 1'b0); // lw $8,0($1)
        step();
        drive(1'b1, 6'b000000, 6'b100000, 5'd8, 5'd2, 5'd9, 1'b0); // add $9,$8,$2
        n_checks++; if ((stall !== 1'b1) || (flush_cnt !== 16'd1)) begin
            n_fail++; $display("FAIL rst_setup got=%b/%0d exp=1/1", stall, flush_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL async_rst_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
        n_checks++; if ({stall_cnt, flush_cnt} !== 32'd0) begin n_fail++; $display("FAIL async_rst_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
        n_checks++; if ((stall !== 1'b0) || (flush !== 1'b0)) begin n_fail++; $display("FAIL async_rst_out got=%b%b exp=00", stall, flush); end
        #1;
        rst = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL post_rst_stall got=%b exp=0", stall); end
        step();
        idle();
        n_checks++; if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL post_rst_fwd got=%b exp=00", fwd_a); end
    endtask

    task automatic test_stall_saturation();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 6'b100011, 6'd0, 5'd1, 5'd8, 5'd0, 1'b0); // lw $8,0($1)
            step();
            drive(1'b1, 6'b000000, 6'b100000, 5'd8, 5'd2, 5'd9, 1'b0); // add $9,$8,$2
            step();
            step();
        end
        idle();
        n_checks++; if (s_stall_cnt !== 3'b111) begin n_fail++; $display("FAIL sat_stall_cnt got=%0d exp=7", s_stall_cnt); end
        n_checks++; if (stall_cnt !== 16'd9) begin n_fail++; $display("FAIL wide_stall_cnt got=%0d exp=9", stall_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #3;
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_load_use();
        test_redirect_priority();
        test_zero_and_nonwriters();
        test_back_to_back();
        test_stall_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
